spi_xfer_ctrl: RTL and testbench

Transfer sequencer for the SPI master datapath. It sits between the register/bus front end and `spi_clkgen`. It gates the SPI clock generator through `clk_en_o` and marks the final clock period through `last_clk_o`. It consumes the generator's one-cycle `spi_rise`/`spi_fall` strobes to shift MOSI and sample MISO, and it frames each transfer with chip-select setup and hold delays.

---
 rtl/spi_xfer_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: frames a 1..32-bit transfer with CS setup/hold, gates spi_clkgen, shifts MOSI and samples MISO.
// Latency: busy/cs_n assert 1 cycle after start; done_o arrives CS_DLY+1 cycles after the exit strobe.
// Backpressure: none; start_i is taken only in IDLE and dropped while busy, abort_i returns to IDLE on the next edge.
module spi_xfer_ctrl #(
  parameter int CS_DLY = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              cpha_i,
  input  logic [4:0]        len_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              spi_rise_i,
  input  logic              spi_fall_i,
  input  logic              miso_i,
  output logic              clk_en_o,
  output logic              last_clk_o,
  output logic              cs_n_o,
  output logic              mosi_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

  localparam logic [7:0] DLY_LAST = 8'(CS_DLY - 1);

  state_t            r_state, w_state_nxt;
  logic [4:0]        r_len, w_len_nxt;
  logic              r_cpha, w_cpha_nxt;
  logic              r_first, w_first_nxt;
  logic [DATA_W-1:0] r_tx_sr, w_tx_nxt;
  logic [DATA_W-1:0] r_rx_sr, w_rx_nxt;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
  logic [5:0]        r_bcnt, w_bcnt_nxt, w_bcnt_s;
  logic [7:0]        r_dcnt, w_dcnt_nxt;
  logic              r_clk_en, w_clk_en_nxt;
  logic              r_last, w_last_nxt;
  logic              r_cs_n, w_cs_n_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  logic [5:0]        w_n;
  logic              w_smp_stb;
  logic              w_sft_stb;
  logic [DATA_W-1:0] w_mask;

  assign w_n       = {1'b0, r_len} + 6'd1;
  assign w_smp_stb = r_cpha ? spi_fall_i : spi_rise_i;
  assign w_sft_stb = r_cpha ? spi_rise_i : spi_fall_i;
  // Shift by 32 yields zero, so the mask is all ones for a full-width transfer.
  assign w_mask    = ~({DATA_W{1'b1}} << w_n);

  // State and datapath registers; every output is taken straight from a flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_cpha    <= 1'b0;
      r_first   <= 1'b0;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_rx_data <= '0;
      r_bcnt    <= '0;
      r_dcnt    <= '0;
      r_clk_en  <= 1'b0;
      r_last    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_len     <= w_len_nxt;
      r_cpha    <= w_cpha_nxt;
      r_first   <= w_first_nxt;
      r_tx_sr   <= w_tx_nxt;
      r_rx_sr   <= w_rx_nxt;
      r_rx_data <= w_rx_data_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_clk_en  <= w_clk_en_nxt;
      r_last    <= w_last_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state, shift/sample and registered-output decode; sample is applied before shift.
  always_comb begin
    w_state_nxt   = r_state;
    w_len_nxt     = r_len;
    w_cpha_nxt    = r_cpha;
    w_first_nxt   = r_first;
    w_tx_nxt      = r_tx_sr;
    w_rx_nxt      = r_rx_sr;
    w_rx_data_nxt = r_rx_data;
    w_bcnt_nxt    = r_bcnt;
    w_bcnt_s      = r_bcnt;
    w_dcnt_nxt    = r_dcnt;
    w_done_nxt    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          w_len_nxt   = len_i;
          w_cpha_nxt  = cpha_i;
          w_first_nxt = 1'b1;
          // Left-align so the first bit to send always sits in the MSB.
          w_tx_nxt    = tx_data_i << (DATA_W - 1 - int'(len_i));
          w_rx_nxt    = '0;
          w_bcnt_nxt  = '0;
          w_dcnt_nxt  = '0;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_dcnt == DLY_LAST) begin
          w_dcnt_nxt  = '0;
          w_state_nxt = S_XFER;
        end else begin
          w_dcnt_nxt = r_dcnt + 8'd1;
        end
      end
      S_XFER: begin
        if (w_smp_stb && (r_bcnt < w_n)) begin
          w_rx_nxt = {r_rx_sr[DATA_W-2:0], miso_i};
          w_bcnt_s = r_bcnt + 6'd1;
        end
        w_bcnt_nxt = w_bcnt_s;
        if (w_sft_stb) begin
          // With cpha=1 the leading rise only opens the first bit; nothing moves yet.
          if (r_cpha && r_first) begin
            w_first_nxt = 1'b0;
          end else if (w_bcnt_s < w_n) begin
            w_tx_nxt = r_tx_sr << 1;
          end
        end
        // Both modes finish on a fall once all N bits are in, leaving SCK idle-low.
        if (spi_fall_i && (w_bcnt_s == w_n)) begin
          w_dcnt_nxt  = '0;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_dcnt == DLY_LAST) begin
          w_state_nxt   = S_IDLE;
          w_done_nxt    = 1'b1;
          w_rx_data_nxt = r_rx_sr & w_mask;
        end else begin
          w_dcnt_nxt = r_dcnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (abort_i && (r_state != S_IDLE)) begin
      w_state_nxt   = S_IDLE;
      w_done_nxt    = 1'b0;
      w_rx_data_nxt = r_rx_data;
    end

    w_clk_en_nxt = (w_state_nxt == S_XFER);
    w_last_nxt   = w_clk_en_nxt && (w_bcnt_nxt >= {1'b0, w_len_nxt});
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    w_cs_n_nxt   = (w_state_nxt == S_IDLE);
  end

  assign clk_en_o   = r_clk_en;
  assign last_clk_o = r_last;
  assign cs_n_o     = r_cs_n;
  assign mosi_o     = r_tx_sr[DATA_W-1];
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign rx_data_o  = r_rx_data;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: directed and random transfers against a bit-level model with an SPI clock generator stand-in.
// Latency: checks CS setup, clock enable, exit-to-done and done pulse timing per transfer.
// Backpressure: exercises held start, abort and reset in each active phase.
module tb_spi_xfer_ctrl;

  localparam int CS_DLY = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        cpha_i = 1'b0;
  logic [4:0]  len_i = '0;
  logic [31:0] tx_data_i = '0;
  logic        spi_rise_i = 1'b0;
  logic        spi_fall_i = 1'b0;
  logic        miso_i = 1'b0;
  logic        clk_en_o, last_clk_o, cs_n_o, mosi_o, busy_o, done_o;
  logic [31:0] rx_data_o;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] model_rx = '0;

  spi_xfer_ctrl #(.CS_DLY(CS_DLY), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .cpha_i(cpha_i), .len_i(len_i), .tx_data_i(tx_data_i),
    .spi_rise_i(spi_rise_i), .spi_fall_i(spi_fall_i), .miso_i(miso_i),
    .clk_en_o(clk_en_o), .last_clk_o(last_clk_o), .cs_n_o(cs_n_o),
    .mosi_o(mosi_o), .busy_o(busy_o), .done_o(done_o), .rx_data_o(rx_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Abort or reset issued at the current negedge; verify the block drops back to idle cleanly.
  task automatic do_kill(input int kind);
    int nd = 0;
    if (kind == 1) abort_i = 1'b1;
    else           rst_i   = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0; rst_i = 1'b0; start_i = 1'b0;
    spi_rise_i = 1'b0; spi_fall_i = 1'b0;
    check("kill_clken", clk_en_o, 0);
    check("kill_csn", cs_n_o, 1);
    check("kill_busy", busy_o, 0);
    check("kill_done", done_o, 0);
    check("kill_last", last_clk_o, 0);
    if (kind == 2) begin
      model_rx = '0;
      check("rst_mosi", mosi_o, 0);
    end
    check("kill_rx", rx_data_o, model_rx);
    repeat (2*CS_DLY + 6) begin
      @(negedge clk_i);
      if (done_o) nd++;
    end
    check("kill_no_done", nd, 0);
    check("kill_rx_hold", rx_data_o, model_rx);
  endtask

  // miso_mode: 0 loopback, 1 random, 2 constant one.
  // kill_kind: 0 none, 1 abort, 2 reset; kill_phase: 1 setup, 2 at sample kill_smp, 3 hold.
  task automatic xfer(input logic [4:0] len, input logic [31:0] tx, input logic cpha,
                      input int miso_mode, input int div, input bit cont, input bit keep,
                      input int kill_kind, input int kill_phase, input int kill_smp);
    int          n = int'(len) + 1;
    int          c = 0, cx = -1, first_en = -1, smp = 0, rises = 0, gcnt = 0;
    int          lc_err = 0, cs_lo = 0;
    bit          sclk = 0, r, f, b, was_smp, fired;
    logic [31:0] exp_rx = '0, mosi_w = '0;
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    if (!cont) @(negedge clk_i);
    start_i = 1'b1; len_i = len; tx_data_i = tx; cpha_i = cpha;
    @(negedge clk_i);
    c = 1;
    if (!keep) start_i = 1'b0;
    check("start_busy", busy_o, 1);
    check("start_csn", cs_n_o, 0);
    check("start_mosi", mosi_o, tx[n-1]);
    check("start_done", done_o, 0);
    while (c < 3000) begin
      if (done_o) break;
      if (!cs_n_o) cs_lo++;
      if (cx >= 0 && c == cx + 1) check("exit_clken_off", clk_en_o, 0);
      if (clk_en_o && first_en < 0) first_en = c;
      if (clk_en_o) begin
        if (last_clk_o !== (smp >= n - 1)) lc_err++;
      end else if (last_clk_o) lc_err++;
      r = 0; f = 0; was_smp = 0;
      if (clk_en_o) begin
        gcnt++;
        if (gcnt >= div) begin
          gcnt = 0; sclk = !sclk;
          if (sclk) r = 1; else f = 1;
        end
      end else begin
        gcnt = 0; sclk = 0;
      end
      if (r) rises++;
      if ((cpha ? f : r) && smp < n) begin
        mosi_w = {mosi_w[30:0], mosi_o};
        b = (miso_mode == 0) ? mosi_o : (miso_mode == 2) ? 1'b1 : 1'($urandom);
        miso_i = b;
        exp_rx = {exp_rx[30:0], b};
        smp++;
        was_smp = 1;
      end
      if (f && smp == n && cx < 0) cx = c;
      spi_rise_i = r; spi_fall_i = f;
      fired = (kill_kind != 0) &&
              ((kill_phase == 1 && c == 1) ||
               (kill_phase == 2 && was_smp && smp == kill_smp) ||
               (kill_phase == 3 && cx >= 0 && c == cx + 1));
      if (fired) begin
        do_kill(kill_kind);
        return;
      end
      @(negedge clk_i);
      c++;
    end
    spi_rise_i = 1'b0; spi_fall_i = 1'b0;
    check("done_seen", done_o, 1);
    check("rx_data", rx_data_o, exp_rx);
    check("mosi_bits", mosi_w, tx & m[31:0]);
    check("rise_cnt", rises, n);
    check("clken_lat", first_en, CS_DLY + 1);
    check("done_lat", c, cx + 1 + CS_DLY);
    check("last_clk", lc_err, 0);
    check("cs_low", cs_lo, cx + CS_DLY);
    check("done_csn", cs_n_o, 1);
    check("done_busy", busy_o, 0);
    model_rx = exp_rx;
    if (!keep) begin
      @(negedge clk_i);
      check("done_pulse", done_o, 0);
    end
  endtask

  initial begin
    int          ln;
    logic [31:0] tx;
    repeat (3) @(negedge clk_i);
    check("rst_csn", cs_n_o, 1);
    check("rst_clken", clk_en_o, 0);
    check("rst_last", last_clk_o, 0);
    check("rst_mosi", mosi_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rx", rx_data_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_busy", busy_o, 0);

    // Directed cases: loopback modes, minimum length.
    xfer(5'd7, 32'hA5, 1'b0, 0, 3, 0, 0, 0, 0, 0);
    xfer(5'd31, 32'hDEADBEEF, 1'b1, 0, 3, 0, 0, 0, 0, 0);
    xfer(5'd0, 32'h1, 1'b0, 2, 3, 0, 0, 0, 0, 0);

    // Abort on the 4th sample, then a normal transfer.
    xfer(5'd15, 32'h1234_5678, 1'b0, 1, 3, 0, 0, 1, 2, 4);
    xfer(5'd15, 32'h0000_C3A5, 1'b1, 0, 2, 0, 0, 0, 0, 0);

    // Start held high: three back-to-back frames.
    xfer(5'd3, 32'h9, 1'b0, 1, 2, 0, 1, 0, 0, 0);
    xfer(5'd3, 32'h9, 1'b0, 1, 2, 1, 1, 0, 0, 0);
    xfer(5'd3, 32'h9, 1'b0, 1, 2, 1, 0, 0, 0, 0);

    // Reset in XFER, HOLD and SETUP, each followed by a good transfer.
    xfer(5'd7, 32'h5A, 1'b0, 0, 2, 0, 0, 2, 2, 3);
    xfer(5'd7, 32'h3C, 1'b1, 0, 2, 0, 0, 0, 0, 0);
    xfer(5'd7, 32'h5A, 1'b1, 1, 2, 0, 0, 2, 3, 0);
    xfer(5'd4, 32'h15, 1'b0, 0, 4, 0, 0, 0, 0, 0);
    xfer(5'd7, 32'h5A, 1'b0, 0, 2, 0, 0, 2, 1, 0);
    xfer(5'd9, 32'h2AB, 1'b1, 1, 3, 0, 0, 0, 0, 0);

    // Abort during HOLD.
    xfer(5'd2, 32'h5, 1'b0, 1, 2, 0, 0, 1, 3, 0);

    // Random transfers, with an occasional abort at a random sample.
    for (int i = 0; i < 24; i++) begin
      ln = $urandom_range(0, 31);
      tx = $urandom;
      if (i % 6 == 5)
        xfer(5'(ln), tx, 1'($urandom_range(0, 1)), 1, $urandom_range(2, 5), 0, 0,
             1, 2, $urandom_range(1, ln + 1));
      else
        xfer(5'(ln), tx, 1'($urandom_range(0, 1)), $urandom_range(0, 1),
             $urandom_range(2, 5), 0, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
